// File: rtl/window3x3_buffer.sv
// window3x3_buffer: builds a 3x3 neighbourhood of RGB444 pixels from a raster
// stream using two line buffers and a two-column shift window. A window is
// emitted only for interior centres, one cycle after the completing pixel is
// accepted. Frames begin on in_sof, and pixels that arrive after a frame has
// ended, without a new in_sof, are flagged as an overrun.
//
// Interface handshake: in_valid qualifies in_pixel/in_sof for exactly one
// cycle with no backpressure; win_valid qualifies the taps, win_x and win_y
// for exactly one cycle; taps hold their previous value while win_valid=0.
module window3x3_buffer #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   localparam int XW = $clog2(IMG_WIDTH),
   localparam int YW = $clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [11:0]   in_pixel,
   input  logic          in_valid,
   input  logic          in_sof,
   output logic [11:0]   win_lu,
   output logic [11:0]   win_mu,
   output logic [11:0]   win_ru,
   output logic [11:0]   win_lm,
   output logic [11:0]   win_mm,
   output logic [11:0]   win_rm,
   output logic [11:0]   win_ld,
   output logic [11:0]   win_md,
   output logic [11:0]   win_rd,
   output logic          win_valid,
   output logic [XW-1:0] win_x,
   output logic [YW-1:0] win_y,
   output logic          frame_done,
   output logic          frame_err
);

   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   // ST_WAIT_FIRST: after reset, stray pixels are dropped silently.
   // ST_RUN:        inside a frame.
   // ST_WAIT_SOF:   frame finished; stray pixels are dropped and flagged.
   typedef enum logic [1:0] {
      ST_WAIT_FIRST = 2'd0,
      ST_RUN        = 2'd1,
      ST_WAIT_SOF   = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Input raster position of the next pixel.
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;

   // Position of the pixel on the input this cycle (in_sof forces origin).
   logic [XW-1:0] ex;
   logic [YW-1:0] ey;

   // Decoded control for this cycle.
   logic in_frame;
   logic drop_err;
   logic last_pix;
   logic qualify;

   // Line buffers: lb1 holds row cy-1, lb2 holds row cy-2.
   logic [11:0] lb1 [IMG_WIDTH];
   logic [11:0] lb2 [IMG_WIDTH];
   logic [11:0] rd1;
   logic [11:0] rd2;

   // Shift window columns: col1 is column x-1, col2 is column x-2 (u/m/d).
   logic [11:0] col1_u, col1_m, col1_d;
   logic [11:0] col2_u, col2_m, col2_d;

   // Effective coordinates: a start-of-frame pixel is always (0, 0).
   always_comb begin
      ex = cx;
      ey = cy;
      if (in_sof) begin
         ex = '0;
         ey = '0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_WAIT_FIRST;
      else     state <= state_next;
   end

   // Next-state logic: in_sof (re)starts a frame, the last pixel ends it.
   always_comb begin
      state_next = state;
      if (in_valid && in_sof) state_next = ST_RUN;
      if (in_frame && last_pix) state_next = ST_WAIT_SOF;
   end

   // Output decode of the FSM together with position qualifiers.
   always_comb begin
      in_frame = in_valid && (in_sof || (state == ST_RUN));
      drop_err = in_valid && !in_sof && (state == ST_WAIT_SOF);
      last_pix = (ex == X_LAST) && (ey == Y_LAST);
      qualify  = in_frame && (ex >= XW'(2)) && (ey >= YW'(2));
   end

   // Raster counters advance on every in-frame pixel and wrap at line end.
   always_ff @(posedge clk) begin
      if (rst) begin
         cx <= '0;
         cy <= '0;
      end else if (in_frame) begin
         if (ex == X_LAST) begin
            cx <= '0;
            cy <= (ey == Y_LAST) ? '0 : ey + YW'(1);
         end else begin
            cx <= ex + XW'(1);
            cy <= ey;
         end
      end
   end

   // Line buffer read at the current column (returns the rows above).
   always_comb begin
      rd1 = lb1[ex];
      rd2 = lb2[ex];
   end

   // Line buffer update: the row above moves down one buffer, new pixel enters.
   // No reset: rows 0 and 1 of every frame overwrite both lines before any
   // window can use them.
   always_ff @(posedge clk) begin
      if (in_frame) begin
         lb1[ex] <= in_pixel;
         lb2[ex] <= rd1;
      end
   end

   // Shift window: each in-frame pixel pushes the new column in from the right.
   always_ff @(posedge clk) begin
      if (rst) begin
         col1_u <= '0;
         col1_m <= '0;
         col1_d <= '0;
         col2_u <= '0;
         col2_m <= '0;
         col2_d <= '0;
      end else if (in_frame) begin
         col2_u <= col1_u;
         col2_m <= col1_m;
         col2_d <= col1_d;
         col1_u <= rd2;
         col1_m <= rd1;
         col1_d <= in_pixel;
      end
   end

   // Registered taps: loaded only for interior centres, otherwise held.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_lu <= '0;
         win_mu <= '0;
         win_ru <= '0;
         win_lm <= '0;
         win_mm <= '0;
         win_rm <= '0;
         win_ld <= '0;
         win_md <= '0;
         win_rd <= '0;
         win_x  <= '0;
         win_y  <= '0;
      end else if (qualify) begin
         win_lu <= col2_u;
         win_mu <= col1_u;
         win_ru <= rd2;
         win_lm <= col2_m;
         win_mm <= col1_m;
         win_rm <= rd1;
         win_ld <= col2_d;
         win_md <= col1_d;
         win_rd <= in_pixel;
         win_x  <= ex - XW'(1);
         win_y  <= ey - YW'(1);
      end
   end

   // Registered status: window strobe, end-of-frame pulse, sticky overrun.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         win_valid  <= qualify;
         frame_done <= in_frame && last_pix;
         if (in_valid && in_sof) frame_err <= 1'b0;
         else if (drop_err)      frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_window3x3_buffer.sv
// tb_window3x3_buffer: directed and random raster streams into a 4x3 and a
// 320x240 instance, checked cycle by cycle against an image-array model.
module tb_window3x3_buffer;

   localparam int SW = 4;
   localparam int SH = 3;
   localparam int LW = 320;
   localparam int LH = 240;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // ---------------- small instance ----------------
   logic [11:0] pix_s;
   logic        val_s, sof_s;
   logic [11:0] s_lu, s_mu, s_ru, s_lm, s_mm, s_rm, s_ld, s_md, s_rd;
   logic        s_valid, s_done, s_err;
   logic [1:0]  s_x;
   logic [1:0]  s_y;

   window3x3_buffer #(.IMG_WIDTH(SW), .IMG_HEIGHT(SH)) dut_s (
      .clk(clk), .rst(rst), .in_pixel(pix_s), .in_valid(val_s), .in_sof(sof_s),
      .win_lu(s_lu), .win_mu(s_mu), .win_ru(s_ru),
      .win_lm(s_lm), .win_mm(s_mm), .win_rm(s_rm),
      .win_ld(s_ld), .win_md(s_md), .win_rd(s_rd),
      .win_valid(s_valid), .win_x(s_x), .win_y(s_y),
      .frame_done(s_done), .frame_err(s_err)
   );

   // ---------------- large instance ----------------
   logic [11:0] pix_l;
   logic        val_l, sof_l;
   logic [11:0] l_lu, l_mu, l_ru, l_lm, l_mm, l_rm, l_ld, l_md, l_rd;
   logic        l_valid, l_done, l_err;
   logic [8:0]  l_x;
   logic [7:0]  l_y;

   window3x3_buffer #(.IMG_WIDTH(LW), .IMG_HEIGHT(LH)) dut_l (
      .clk(clk), .rst(rst), .in_pixel(pix_l), .in_valid(val_l), .in_sof(sof_l),
      .win_lu(l_lu), .win_mu(l_mu), .win_ru(l_ru),
      .win_lm(l_lm), .win_mm(l_mm), .win_rm(l_rm),
      .win_ld(l_ld), .win_md(l_md), .win_rd(l_rd),
      .win_valid(l_valid), .win_x(l_x), .win_y(l_y),
      .frame_done(l_done), .frame_err(l_err)
   );

   logic [107:0] s_taps, l_taps;
   assign s_taps = {s_lu, s_mu, s_ru, s_lm, s_mm, s_rm, s_ld, s_md, s_rd};
   assign l_taps = {l_lu, l_mu, l_ru, l_lm, l_mm, l_rm, l_ld, l_md, l_rd};

   // ---------------- reference model ----------------
   // 0 = waiting for first sof, 1 = in frame, 2 = frame over
   int           m_st [2];
   int           m_x  [2];
   int           m_y  [2];
   logic         m_err[2];
   logic         m_v  [2];
   logic         m_done[2];
   logic [107:0] m_taps[2];
   int           m_wx [2];
   int           m_wy [2];
   logic [11:0]  img  [2][LH][LW];

   int compared = 0;
   int mismatched = 0;
   int win_cnt [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_x[d] = 0; m_y[d] = 0; m_err[d] = 1'b0;
         m_v[d] = 1'b0; m_done[d] = 1'b0; m_taps[d] = '0;
         m_wx[d] = 0; m_wy[d] = 0;
      end
   endtask

   task automatic model_step(input int d, input bit v, input bit s, input logic [11:0] p);
      int w, h, x, y;
      w = (d != 0) ? LW : SW;
      h = (d != 0) ? LH : SH;
      m_v[d] = 1'b0;
      m_done[d] = 1'b0;
      if (!v) return;
      if (s) begin
         m_err[d] = 1'b0; m_x[d] = 0; m_y[d] = 0; m_st[d] = 1;
      end else if (m_st[d] == 2) begin
         m_err[d] = 1'b1;
         return;
      end else if (m_st[d] == 0) begin
         return;
      end
      x = m_x[d];
      y = m_y[d];
      img[d][y][x] = p;
      if (x >= 2 && y >= 2) begin
         m_v[d] = 1'b1;
         m_wx[d] = x - 1;
         m_wy[d] = y - 1;
         m_taps[d] = {img[d][y-2][x-2], img[d][y-2][x-1], img[d][y-2][x],
                      img[d][y-1][x-2], img[d][y-1][x-1], img[d][y-1][x],
                      img[d][y][x-2],   img[d][y][x-1],   img[d][y][x]};
      end
      if (x == w - 1 && y == h - 1) begin
         m_done[d] = 1'b1;
         m_st[d] = 2;
         m_x[d] = 0; m_y[d] = 0;
      end else if (x == w - 1) begin
         m_x[d] = 0; m_y[d] = y + 1;
      end else begin
         m_x[d] = x + 1;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input int d);
      logic ov, od, oe;
      logic [107:0] ot;
      int ox, oy;
      ov = (d != 0) ? l_valid : s_valid;
      od = (d != 0) ? l_done  : s_done;
      oe = (d != 0) ? l_err   : s_err;
      ot = (d != 0) ? l_taps  : s_taps;
      ox = (d != 0) ? int'(l_x) : int'(s_x);
      oy = (d != 0) ? int'(l_y) : int'(s_y);
      if (ov === 1'b1) win_cnt[d]++;
      chk("win_valid", 108'(ov), 108'(m_v[d]));
      chk("frame_done", 108'(od), 108'(m_done[d]));
      chk("frame_err", 108'(oe), 108'(m_err[d]));
      chk("taps", ot, m_taps[d]);
      if (m_v[d]) begin
         chk("win_x", 108'(ox), 108'(m_wx[d]));
         chk("win_y", 108'(oy), 108'(m_wy[d]));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input int d, input bit v, input bit s, input logic [11:0] p);
      val_s = 1'b0; sof_s = 1'b0; pix_s = '0;
      val_l = 1'b0; sof_l = 1'b0; pix_l = '0;
      if (d != 0) begin val_l = v; sof_l = s; pix_l = p; end
      else        begin val_s = v; sof_s = s; pix_s = p; end
      @(posedge clk);
      model_step(d, v, s, p);
      #1;
      check_dut(d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      val_s = 1'b0; sof_s = 1'b0; pix_s = '0;
      val_l = 1'b0; sof_l = 1'b0; pix_l = '0;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
      check_dut(0);
      check_dut(1);
   endtask

   task automatic small_frame(input bit gaps, input bit rnd, input bit rnd_gaps);
      for (int i = 0; i < SW * SH; i++) begin
         logic [11:0] p;
         p = rnd ? 12'($urandom) : 12'(i);
         if (rnd_gaps) begin
            while ($urandom_range(0, 3) == 0) cycle(0, 1'b0, 1'b0, 12'h0);
         end
         cycle(0, 1'b1, (i == 0), p);
         if (gaps) cycle(0, 1'b0, 1'b0, 12'h0);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [107:0] first_win;
      first_win = {12'h000, 12'h001, 12'h002, 12'h004, 12'h005, 12'h006,
                   12'h008, 12'h009, 12'h00A};
      win_cnt[0] = 0;
      win_cnt[1] = 0;
      rst = 1'b1;
      val_s = 1'b0; sof_s = 1'b0; pix_s = '0;
      val_l = 1'b0; sof_l = 1'b0; pix_l = '0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      // Pixels before the first sof: dropped, no error.
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0, 12'(i + 12'h100));
      chk("pre_sof_err", 108'(s_err), 108'(0));

      // 4x3 ramp frame: two windows, frame_done with the second.
      win_cnt[0] = 0;
      for (int i = 0; i < SW * SH; i++) begin
         cycle(0, 1'b1, (i == 0), 12'(i));
         if (i == 10) chk("ramp_first_window", s_taps, first_win);
         if (i == 11) chk("ramp_done_with_win", 108'({s_done, s_valid}), 108'(3));
      end
      cycle(0, 1'b0, 1'b0, 12'h0);
      chk("ramp_win_count", 108'(win_cnt[0]), 108'(2));

      // Same ramp with in_valid low every other cycle.
      win_cnt[0] = 0;
      small_frame(1'b1, 1'b0, 1'b0);
      chk("gap_win_count", 108'(win_cnt[0]), 108'(2));
      chk("gap_taps_hold", s_taps, {12'h001, 12'h002, 12'h003, 12'h005, 12'h006,
                                    12'h007, 12'h009, 12'h00A, 12'h00B});

      // Overrun after frame end, then recovery on sof.
      for (int i = 0; i < 3; i++) cycle(0, 1'b1, 1'b0, 12'($urandom));
      chk("overrun_err", 108'(s_err), 108'(1));
      cycle(0, 1'b1, 1'b1, 12'($urandom));
      chk("sof_clears_err", 108'(s_err), 108'(0));
      for (int i = 1; i < SW * SH; i++) cycle(0, 1'b1, 1'b0, 12'($urandom));

      // Restart: sof at pixel 6 of a frame, then a full new frame.
      for (int i = 0; i < 6; i++) cycle(0, 1'b1, (i == 0), 12'($urandom));
      win_cnt[0] = 0;
      small_frame(1'b0, 1'b1, 1'b0);
      chk("restart_win_count", 108'(win_cnt[0]), 108'(2));

      // Reset mid-row, then stray pixels, then a full frame.
      for (int i = 0; i < 5; i++) cycle(0, 1'b1, (i == 0), 12'($urandom));
      do_reset();
      chk("rst_outputs_zero", {s_taps[95:0], s_valid, s_done, s_err},
          {96'h0, 3'b000});
      win_cnt[0] = 0;
      for (int i = 0; i < 8; i++) cycle(0, 1'b1, 1'b0, 12'($urandom));
      chk("post_rst_no_win", 108'(win_cnt[0]), 108'(0));
      chk("post_rst_no_err", 108'(s_err), 108'(0));

      // Random frames with random gaps.
      for (int f = 0; f < 6; f++) begin
         win_cnt[0] = 0;
         small_frame(1'b0, 1'b1, 1'b1);
         cycle(0, 1'b0, 1'b0, 12'h0);
         chk("rand_win_count", 108'(win_cnt[0]), 108'(2));
      end

      // Full-size random frame.
      win_cnt[1] = 0;
      for (int i = 0; i < LW * LH; i++) cycle(1, 1'b1, (i == 0), 12'($urandom));
      cycle(1, 1'b0, 1'b0, 12'h0);
      chk("large_win_count", 108'(win_cnt[1]), 108'(318 * 238));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
